// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM states, access size codes,
// and the alignment rule used to reject requests.
package lsu_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD      = 3'd1,
        RD_WAIT = 3'd2,
        WR      = 3'd3,
        RESP    = 3'd4
    } lsu_state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    // Illegal size or a lane offset that does not fit the access size.
    function automatic logic size_err(input logic [1:0] size, input logic [1:0] off);
        logic err;
        case (size)
            SZ_BYTE: err = 1'b0;
            SZ_HALF: err = off[0];
            SZ_WORD: err = (off != 2'b00);
            default: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering: extracts/extends sub-word load data and merges store data
// into a memory word (little-endian lanes).
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]        size_i,
    input  logic              signed_i,
    input  logic [1:0]        offset_i,
    input  logic [DATA_W-1:0] mem_word_i,
    input  logic [DATA_W-1:0] store_data_i,
    output logic [DATA_W-1:0] load_data_o,
    output logic [DATA_W-1:0] merged_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Load path: pick the addressed lanes, then zero- or sign-extend.
    always_comb begin
        byte_s      = 8'd0;
        half_s      = 16'd0;
        load_data_o = mem_word_i;
        case (offset_i)
            2'd0:    byte_s = mem_word_i[7:0];
            2'd1:    byte_s = mem_word_i[15:8];
            2'd2:    byte_s = mem_word_i[23:16];
            2'd3:    byte_s = mem_word_i[31:24];
            default: byte_s = 8'd0;
        endcase
        if (offset_i[1]) begin
            half_s = mem_word_i[31:16];
        end else begin
            half_s = mem_word_i[15:0];
        end
        case (size_i)
            SZ_BYTE: load_data_o = {{24{signed_i & byte_s[7]}}, byte_s};
            SZ_HALF: load_data_o = {{16{signed_i & half_s[15]}}, half_s};
            default: load_data_o = mem_word_i;
        endcase
    end

    // Store path: replace only the addressed lanes of the old word.
    always_comb begin
        merged_o = mem_word_i;
        case (size_i)
            SZ_BYTE: begin
                case (offset_i)
                    2'd0:    merged_o[7:0]   = store_data_i[7:0];
                    2'd1:    merged_o[15:8]  = store_data_i[7:0];
                    2'd2:    merged_o[23:16] = store_data_i[7:0];
                    2'd3:    merged_o[31:24] = store_data_i[7:0];
                    default: merged_o        = mem_word_i;
                endcase
            end
            SZ_HALF: begin
                if (offset_i[1]) begin
                    merged_o[31:16] = store_data_i[15:0];
                end else begin
                    merged_o[15:0]  = store_data_i[15:0];
                end
            end
            SZ_WORD: merged_o = store_data_i;
            default: merged_o = mem_word_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit fronting a synchronous single-port word memory; sub-word
// stores are done as read-modify-write.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W+1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    lsu_state_t        state_q, state_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              signed_q, signed_d;
    logic [ADDR_W+1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_err_q, resp_err_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;

    logic              accept_s;
    logic              err_s;
    logic [DATA_W-1:0] load_data_s;
    logic [DATA_W-1:0] merged_s;

    assign accept_s = req_valid & req_ready;
    assign err_s    = size_err(req_size, req_addr[1:0]);

    lsu_align u_align (
        .size_i       (size_q),
        .signed_i     (signed_q),
        .offset_i     (addr_q[1:0]),
        .mem_word_i   (mem_dout),
        .store_data_i (wdata_q),
        .load_data_o  (load_data_s),
        .merged_o     (merged_s)
    );

    // State and datapath registers; reset wins over any handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            size_q       <= 2'b00;
            signed_q     <= 1'b0;
            addr_q       <= {(ADDR_W+2){1'b0}};
            wdata_q      <= {DATA_W{1'b0}};
            data_q       <= {DATA_W{1'b0}};
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= {DATA_W{1'b0}};
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            size_q       <= size_d;
            signed_q     <= signed_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            data_q       <= data_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    // Next-state sequencing.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    if (err_s) begin
                        state_d = RESP;
                    end else if (req_we && (req_size == SZ_WORD)) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RD:      state_d = RD_WAIT;
            RD_WAIT: begin
                if (we_q) begin
                    state_d = WR;
                end else begin
                    state_d = RESP;
                end
            end
            WR:      state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request capture, RMW word capture and response register loading.
    always_comb begin
        if (accept_s) begin
            we_d     = req_we;
            size_d   = req_size;
            signed_d = req_signed;
            addr_d   = req_addr;
            wdata_d  = req_wdata;
        end else begin
            we_d     = we_q;
            size_d   = size_q;
            signed_d = signed_q;
            addr_d   = addr_q;
            wdata_d  = wdata_q;
        end
        if (state_q == RD_WAIT) begin
            data_d = merged_s;
        end else begin
            data_d = data_q;
        end
        // Response registers are only non-zero in the single RESP cycle.
        resp_valid_d = (state_d == RESP);
        resp_err_d   = accept_s & err_s;
        if ((state_q == RD_WAIT) && !we_q) begin
            resp_rdata_d = load_data_s;
        end else begin
            resp_rdata_d = {DATA_W{1'b0}};
        end
    end

    // Memory port and handshake outputs decoded from the current state.
    always_comb begin
        req_ready = (state_q == IDLE);
        mem_we    = 1'b0;
        mem_addr  = {ADDR_W{1'b0}};
        mem_din   = {DATA_W{1'b0}};
        case (state_q)
            RD, RD_WAIT: begin
                mem_addr = addr_q[ADDR_W+1:2];
            end
            WR: begin
                mem_we   = 1'b1;
                mem_addr = addr_q[ADDR_W+1:2];
                if (size_q == SZ_WORD) begin
                    mem_din = wdata_q;
                end else begin
                    mem_din = data_q;
                end
            end
            default: begin
                mem_we   = 1'b0;
                mem_addr = {ADDR_W{1'b0}};
                mem_din  = {DATA_W{1'b0}};
            end
        endcase
    end

    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed and random requests checked against a
// byte-lane reference model of memory.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [9:0]  req_addr = 10'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;

    logic        fill_en = 1'b0;
    logic [7:0]  fill_idx = 8'd0;
    logic [31:0] fill_val = 32'd0;
    logic [31:0] mem [0:255];
    logic [31:0] ref_mem [0:255];

    int errors = 0;
    int checks = 0;

    load_store_unit #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout)
    );

    always #5 clk = ~clk;

    // Synchronous single-port memory, with a fill port used during reset.
    always @(posedge clk) begin
        if (fill_en) mem[fill_idx] <= fill_val;
        else if (mem_we) mem[mem_addr] <= mem_din;
        mem_dout <= mem[mem_addr];
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] w, input int off, input int nb, input bit sg);
        logic [31:0] v;
        v = w >> (off * 8);
        if (nb == 1) begin
            v = v & 32'h0000_00FF;
            if (sg && v[7]) v = v | 32'hFFFF_FF00;
        end else if (nb == 2) begin
            v = v & 32'h0000_FFFF;
            if (sg && v[15]) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] w, input int off, input int nb, input logic [31:0] wd);
        logic [63:0] m;
        m = ((64'd1 << (nb * 8)) - 64'd1) << (off * 8);
        return (w & ~m[31:0]) | ((wd << (off * 8)) & m[31:0]);
    endfunction

    // One complete request, called at a falling edge with the unit idle.
    task automatic do_op(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [9:0] a, input logic [31:0] wd, input string tag);
        logic [31:0] w, exp_rd, newv, got_rd;
        logic        got_err, rdy_after;
        bit          err;
        int          off, nb, lat, first, pulses, wecnt, dirty;
        off = int'(a[1:0]);
        w   = ref_mem[a[9:2]];
        err = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && off != 0);
        nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        if (err) begin
            lat = 1; exp_rd = 32'd0; newv = w;
        end else if (we) begin
            lat = (nb == 4) ? 2 : 4; exp_rd = 32'd0; newv = ref_store(w, off, nb, wd);
        end else begin
            lat = 3; exp_rd = ref_load(w, off, nb, sg); newv = w;
        end
        check({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
        req_signed = 1'($urandom); req_addr = 10'($urandom); req_wdata = $urandom;
        first = 0; pulses = 0; wecnt = 0; dirty = 0;
        got_rd = 32'd0; got_err = 1'b0; rdy_after = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (resp_valid) begin
                pulses++;
                if (first == 0) begin
                    first = k; got_rd = resp_rdata; got_err = resp_err;
                end
                if (mem_we || mem_addr != 8'd0 || mem_din != 32'd0) dirty++;
            end else if (resp_rdata != 32'd0 || resp_err) begin
                dirty++;
            end
            if (mem_we) wecnt++;
            if (k == lat + 1) rdy_after = req_ready;
        end
        check({tag, "_latency"}, 32'(first), 32'(lat));
        check({tag, "_pulses"}, 32'(pulses), 32'd1);
        check({tag, "_rdata"}, got_rd, exp_rd);
        check({tag, "_err"}, {31'd0, got_err}, {31'd0, err});
        check({tag, "_we_cycles"}, 32'(wecnt), (!err && we) ? 32'd1 : 32'd0);
        check({tag, "_ready_after"}, {31'd0, rdy_after}, 32'd1);
        check({tag, "_idle_outputs"}, 32'(dirty), 32'd0);
        check({tag, "_memword"}, mem[a[9:2]], newv);
        ref_mem[a[9:2]] = newv;
    endtask

    initial begin
        int pulses, wecnt;
        // Fill memory identically in the bench memory and the reference, under reset.
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            fill_en = 1'b1; fill_idx = 8'(i); fill_val = $urandom;
            ref_mem[i] = fill_val;
        end
        @(negedge clk);
        fill_en = 1'b0;
        @(negedge clk);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_err", {31'd0, resp_err}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
        check("rst_mem_din", mem_din, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", {31'd0, req_ready}, 32'd1);

        do_op(1'b1, 2'b10, 1'b0, 10'h004, 32'hDEADBEEF, "st_word");
        do_op(1'b0, 2'b10, 1'b0, 10'h004, 32'h0, "ld_word");
        check("spec_word", mem[1], 32'hDEADBEEF);
        do_op(1'b1, 2'b10, 1'b0, 10'h008, 32'hCAFEBABE, "st_word8");
        do_op(1'b1, 2'b00, 1'b0, 10'h009, 32'h00000011, "st_byte_rmw");
        do_op(1'b0, 2'b10, 1'b0, 10'h008, 32'h0, "ld_rmw");
        check("spec_rmw", mem[2], 32'hCAFE11BE);
        do_op(1'b1, 2'b10, 1'b0, 10'h00C, 32'h80F0007F, "st_word12");
        do_op(1'b0, 2'b01, 1'b0, 10'h00E, 32'h0, "ld_half_u");
        do_op(1'b0, 2'b01, 1'b1, 10'h00E, 32'h0, "ld_half_s");
        do_op(1'b0, 2'b00, 1'b1, 10'h00C, 32'h0, "ld_byte_s");
        do_op(1'b0, 2'b00, 1'b1, 10'h00F, 32'h0, "ld_byte_s3");
        do_op(1'b1, 2'b01, 1'b0, 10'h00E, 32'h1234ABCD, "st_half_hi");
        do_op(1'b0, 2'b10, 1'b0, 10'h005, 32'h0, "err_ld_word");
        do_op(1'b1, 2'b01, 1'b0, 10'h003, 32'hFFFFFFFF, "err_st_half");
        do_op(1'b1, 2'b11, 1'b0, 10'h000, 32'hFFFFFFFF, "err_size");

        // Reset while a byte RMW sits in RD_WAIT: no write, no response.
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 10'h010; req_wdata = 32'h000000AA;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        pulses = 0; wecnt = 0;
        if (mem_we) wecnt++;
        if (resp_valid) pulses++;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (mem_we) wecnt++;
            if (resp_valid) pulses++;
            @(negedge clk);
            if (k == 0) check("rmw_rst_ready", {31'd0, req_ready}, 32'd1);
        end
        check("rmw_rst_resp", 32'(pulses), 32'd0);
        check("rmw_rst_we", 32'(wecnt), 32'd0);
        check("rmw_rst_mem", mem[4], ref_mem[4]);

        // Reset coinciding with a handshake: request must not be captured.
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 10'h014;
        req_wdata = 32'h12345678; rst = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        pulses = 0; wecnt = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (mem_we) wecnt++;
            if (resp_valid) pulses++;
        end
        check("hs_rst_resp", 32'(pulses), 32'd0);
        check("hs_rst_we", 32'(wecnt), 32'd0);
        check("hs_rst_mem", mem[5], ref_mem[5]);

        for (int n = 0; n < 40; n++) begin
            do_op(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
                  10'($urandom_range(0, 63)), $urandom, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
